// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types for the PicoMIPS program-counter sequencer.
//   opcode_t  - 3-bit instruction class decoded in EXEC (4..6 are NOPs)
//   state_t   - sequencer FSM states
//   PSIZE_DEF - default PC width (program space of 2**PSIZE_DEF words)
package pc_seq_pkg;

  localparam int PSIZE_DEF = 6;

  typedef enum logic [2:0] {
    OP_ALU  = 3'd0,
    OP_BRA  = 3'd1,
    OP_BZ   = 3'd2,
    OP_WAIT = 3'd3,
    OP_HALT = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    EXEC    = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    HALT    = 3'd4
  } state_t;

endpackage

// File: rtl/pc_sequencer_sync2.sv
// sync2: generic two-flop synchronizer with asynchronous active-high clear.
//   clk - destination clock
//   clr - asynchronous clear, both flops go to 0
//   d   - asynchronous input
//   q   - input resynchronized to clk, two cycles of latency
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control unit of the PicoMIPS core. Owns the PC
// and sequences fetch/execute, PC-relative branches, operator-switch input
// and halt.
//
// Ports:
//   clk        - system clock, rising edge
//   SW9        - asynchronous active-high reset
//   SW8        - operator handshake switch (asynchronous to clk)
//   opcode     - instruction class from the synchronous ROM, valid in EXEC
//   branch_off - two's-complement PC-relative offset
//   zero       - ALU zero flag, valid in EXEC
//   pc_out     - ROM address
//   reg_we     - register-file write strobe
//   in_sel     - selects switch data into the register-file write port
//   halted     - high while in HALT
//   state_dbg  - current FSM state (state_t encoding) for observation
//
// Build option: define SW8_SYNC_EN to pass SW8 through a two-flop
// synchronizer (2-cycle latency). Without it SW8 is used directly, which is
// only safe in simulation.
//
// Switch handshake: an OP_WAIT parks the sequencer in WAIT_HI until the
// switch reads 1; that single cycle strobes reg_we/in_sel. It then sits in
// WAIT_LO until the switch reads 0 before stepping the PC, so one press
// produces exactly one register write however long it is held.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int Psize = PSIZE_DEF
) (
  input  logic             clk,
  input  logic             SW9,
  input  logic             SW8,
  input  logic [2:0]       opcode,
  input  logic [Psize-1:0] branch_off,
  input  logic             zero,
  output logic [Psize-1:0] pc_out,
  output logic             reg_we,
  output logic             in_sel,
  output logic             halted,
  output logic [2:0]       state_dbg
);

  localparam logic [Psize-1:0] ONE = {{(Psize-1){1'b0}}, 1'b1};

  logic sw8_s;

`ifdef SW8_SYNC_EN
  sync2 #(.WIDTH(1)) u_sw8_sync (
    .clk (clk),
    .clr (SW9),
    .d   (SW8),
    .q   (sw8_s)
  );
`else
  assign sw8_s = SW8;
`endif

  state_t           state;
  state_t           state_nx;
  logic [Psize-1:0] pc;
  logic [Psize-1:0] operand;
  logic [Psize-1:0] pc_sum;
  logic             pc_load;
  logic             step;

  // Next state, adder operand select and strobes. The single adder either
  // steps by one or applies the branch offset; wraparound is the natural
  // modulo-2**Psize behaviour of the adder.
  always_comb begin
    state_nx = state;
    step     = 1'b1;
    pc_load  = 1'b0;
    reg_we   = 1'b0;
    in_sel   = 1'b0;

    case (state)
      FETCH: state_nx = EXEC;

      EXEC: begin
        state_nx = FETCH;
        pc_load  = 1'b1;
        case (opcode)
          OP_ALU:  reg_we = 1'b1;
          OP_BRA:  step = 1'b0;
          OP_BZ:   step = ~zero;
          OP_WAIT: begin
            pc_load  = 1'b0;
            state_nx = WAIT_HI;
          end
          OP_HALT: begin
            pc_load  = 1'b0;
            state_nx = HALT;
          end
          default: ; // 4..6: NOP, just step the PC
        endcase
      end

      WAIT_HI: begin
        if (sw8_s) begin
          reg_we   = 1'b1;
          in_sel   = 1'b1;
          state_nx = WAIT_LO;
        end
      end

      WAIT_LO: begin
        if (!sw8_s) begin
          pc_load  = 1'b1;
          state_nx = FETCH;
        end
      end

      HALT:    state_nx = HALT;

      default: state_nx = FETCH;
    endcase

    operand = step ? ONE : branch_off;
    pc_sum  = pc + operand;
  end

  always_ff @(posedge clk or posedge SW9) begin
    if (SW9) begin
      state <= FETCH;
      pc    <= '0;
    end else begin
      state <= state_nx;
      if (pc_load) pc <= pc_sum;
    end
  end

  assign pc_out    = pc;
  assign halted    = (state == HALT);
  assign state_dbg = state;

endmodule
